// File: rtl/alarm_tone_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alarm_tone_sequencer                                        |
// | Description : Plays a repeating sequence of square-wave tones from a     |
// |               four-entry frequency table while alarm_trigger is high.    |
// |               Build macro ALARM_SEQ_GAP_EN inserts a silent gap between  |
// |               notes; without it, notes follow back to back.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alarm_tone_sequencer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int NOTE0_HZ    = 1000,
  parameter int NOTE1_HZ    = 2000,
  parameter int NOTE2_HZ    = 1500,
  parameter int NOTE3_HZ    = 3000,
  parameter int NUM_NOTES   = 2,
  parameter int NOTE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_trigger,
  input  logic       mute,
  output logic       speaker_out,
  output logic       busy,
  output logic [1:0] note_idx
);

  function automatic int half_of(input int hz);
    int h;
    h = CLK_HZ / (2 * hz);
    return (h < 1) ? 1 : h;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_HALF0    = half_of(NOTE0_HZ);
  localparam int C_HALF1    = half_of(NOTE1_HZ);
  localparam int C_HALF2    = half_of(NOTE2_HZ);
  localparam int C_HALF3    = half_of(NOTE3_HZ);
  localparam int C_HALF_MAX = max2(max2(C_HALF0, C_HALF1), max2(C_HALF2, C_HALF3));
  localparam int C_HW       = (C_HALF_MAX > 1) ? $clog2(C_HALF_MAX) : 1;

  // One duration counter serves both notes and gaps, so it is sized for the longer.
  localparam int C_DUR_MAX  = max2(NOTE_CYCLES, GAP_CYCLES);
  localparam int C_DW       = (C_DUR_MAX > 1) ? $clog2(C_DUR_MAX) : 1;

  localparam logic [C_HW-1:0] C_HL0       = C_HW'(C_HALF0 - 1);
  localparam logic [C_HW-1:0] C_HL1       = C_HW'(C_HALF1 - 1);
  localparam logic [C_HW-1:0] C_HL2       = C_HW'(C_HALF2 - 1);
  localparam logic [C_HW-1:0] C_HL3       = C_HW'(C_HALF3 - 1);
  localparam logic [C_DW-1:0] C_NOTE_LAST = C_DW'(NOTE_CYCLES - 1);
`ifdef ALARM_SEQ_GAP_EN
  localparam logic [C_DW-1:0] C_GAP_LAST  = C_DW'(GAP_CYCLES - 1);
`endif
  localparam logic [1:0]      C_IDX_LAST  = 2'(NUM_NOTES - 1);

`ifdef ALARM_SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TONE = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TONE = 2'd1} state_t;
`endif

  state_t          state;
  logic [C_DW-1:0] dur_cnt;
  logic [C_HW-1:0] half_cnt;
  logic [C_HW-1:0] half_last;
  logic            tone_phase;
  logic [1:0]      idx_next;

  // Half-period terminal count of the current note and the wrapped successor index.
  always_comb begin
    half_last = C_HL0;
    case (note_idx)
      2'd0:    half_last = C_HL0;
      2'd1:    half_last = C_HL1;
      2'd2:    half_last = C_HL2;
      default: half_last = C_HL3;
    endcase
    idx_next = (note_idx == C_IDX_LAST) ? 2'd0 : note_idx + 2'd1;
  end

  // Sequencer FSM with registered speaker, busy and note index outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      note_idx    <= 2'd0;
      dur_cnt     <= '0;
      half_cnt    <= '0;
      tone_phase  <= 1'b0;
      speaker_out <= 1'b0;
    end else begin
      // The pin follows the phase one cycle later; mute only gates the pin.
      speaker_out <= tone_phase & ~mute;
      if (!alarm_trigger) begin
        // Dropping the request wins over any note or gap boundary this cycle.
        state      <= S_IDLE;
        busy       <= 1'b0;
        note_idx   <= 2'd0;
        dur_cnt    <= '0;
        half_cnt   <= '0;
        tone_phase <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_TONE;
            busy       <= 1'b1;
            note_idx   <= 2'd0;
            dur_cnt    <= '0;
            half_cnt   <= '0;
            tone_phase <= 1'b1;
          end
          S_TONE: begin
            if (dur_cnt == C_NOTE_LAST) begin
              dur_cnt  <= '0;
              half_cnt <= '0;
`ifdef ALARM_SEQ_GAP_EN
              state      <= S_GAP;
              tone_phase <= 1'b0;
`else
              note_idx   <= idx_next;
              tone_phase <= 1'b1;
`endif
            end else begin
              dur_cnt <= dur_cnt + C_DW'(1);
              if (half_cnt == half_last) begin
                half_cnt   <= '0;
                tone_phase <= ~tone_phase;
              end else begin
                half_cnt <= half_cnt + C_HW'(1);
              end
            end
          end
`ifdef ALARM_SEQ_GAP_EN
          S_GAP: begin
            tone_phase <= 1'b0;
            if (dur_cnt == C_GAP_LAST) begin
              state      <= S_TONE;
              note_idx   <= idx_next;
              dur_cnt    <= '0;
              half_cnt   <= '0;
              tone_phase <= 1'b1;
            end else begin
              dur_cnt <= dur_cnt + C_DW'(1);
            end
          end
`endif
          default: begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            note_idx   <= 2'd0;
            dur_cnt    <= '0;
            half_cnt   <= '0;
            tone_phase <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
